// File: rtl/qspi_pkg.sv
// ---------------------------------------------------------------------------
// qspi_pkg
// Types and defaults shared by the QSPI command sequencer and the byte
// shifter that sits between it and the flash pins.
//   lane_mode_e  : lane width used for one byte (single / dual / quad)
//   seq_state_e  : sequencer transaction phase
//   CS_HIGH_CYCLES_DEFAULT : default minimum chip-select high time
//   lane_norm()  : maps the reserved lane encoding onto single-lane
// ---------------------------------------------------------------------------
package qspi_pkg;

  localparam int CS_HIGH_CYCLES_DEFAULT = 2;
  localparam int ADDR_BYTES_DEFAULT     = 3;

  typedef enum logic [1:0] {
    LANE_SINGLE = 2'b00,
    LANE_DUAL   = 2'b01,
    LANE_QUAD   = 2'b10,
    LANE_RSVD   = 2'b11
  } lane_mode_e;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_CMD   = 3'd1,
    SEQ_ADDR  = 3'd2,
    SEQ_DUMMY = 3'd3,
    SEQ_DATA  = 3'd4,
    SEQ_DESEL = 3'd5
  } seq_state_e;

  // The reserved encoding is run as a single-lane byte so a bad mode
  // field never produces an undefined pin pattern in the shifter.
  function automatic lane_mode_e lane_norm(input logic [1:0] raw);
    lane_mode_e m;
    m = lane_mode_e'(raw);
    if (m == LANE_RSVD) begin
      m = LANE_SINGLE;
    end
    return m;
  endfunction

endpackage

// File: rtl/qspi_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// qspi_cmd_sequencer
// Walks one flash transaction through command, address, dummy and data
// phases, handing one byte at a time to an external lane shifter, then
// holds chip select high for a minimum deselect time.
//
// Ports
//   clk_i, rst_n_i             : clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  : request handshake (ready only when idle)
//   cmd_i, addr_i, addr_en_i   : opcode, address, address phase present
//   dummy_i, len_i, wr_i       : dummy cycles, data byte count, direction
//   cmd/addr/data_mode_i       : lane mode per phase (11 runs as single)
//   abort_i                    : terminate the running transaction
//   wdata_i/_valid_i/_ready_o  : write byte stream into the flash
//   rdata_o / rdata_valid_o    : read byte stream, no backpressure
//   done_o / aborted_o         : completion pulse, aborted qualifier
//   cs_o                       : flash chip select, active-low
//   sh_start_o, sh_byte_o, sh_mode_o, sh_dir_o : byte command to shifter
//   sh_done_i, sh_byte_i       : shifter byte completion and captured byte
// ---------------------------------------------------------------------------
module qspi_cmd_sequencer
  import qspi_pkg::*;
#(
  parameter int ADDR_BYTES     = ADDR_BYTES_DEFAULT,
  parameter int CS_HIGH_CYCLES = CS_HIGH_CYCLES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  cmd_i,
  input  logic [31:0] addr_i,
  input  logic        addr_en_i,
  input  logic [3:0]  dummy_i,
  input  logic [8:0]  len_i,
  input  logic        wr_i,
  input  logic [1:0]  cmd_mode_i,
  input  logic [1:0]  addr_mode_i,
  input  logic [1:0]  data_mode_i,
  input  logic        abort_i,
  input  logic [7:0]  wdata_i,
  input  logic        wdata_valid_i,
  output logic        wdata_ready_o,
  output logic [7:0]  rdata_o,
  output logic        rdata_valid_o,
  output logic        done_o,
  output logic        aborted_o,
  output logic        cs_o,
  output logic        sh_start_o,
  output logic [7:0]  sh_byte_o,
  output logic [1:0]  sh_mode_o,
  output logic        sh_dir_o,
  input  logic        sh_done_i,
  input  logic [7:0]  sh_byte_i
);

  // Registered request fields, held for the whole transaction.
  logic [7:0]  cmd_q;
  logic [31:0] addr_q;
  logic        addr_en_q;
  logic [3:0]  dummy_q;
  logic [8:0]  len_q;
  logic        wr_q;
  logic [1:0]  cmd_mode_q;
  logic [1:0]  addr_mode_q;
  logic [1:0]  data_mode_q;

  // Sequencer state and counters.
  seq_state_e  state_q, state_d;
  logic        pend_q, pend_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [3:0]  wait_q, wait_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;

  logic        accept;
  logic        byte_done;
  logic        abort_now;
  logic        enter_tail;
  logic        go_desel;

  assign accept    = req_valid_i && (state_q == SEQ_IDLE);
  // A completion only counts while a byte is actually outstanding; stray
  // shifter pulses in other phases fall through here.
  assign byte_done = pend_q && sh_done_i;
  assign abort_now = abort_i && (state_q == SEQ_CMD  || state_q == SEQ_ADDR ||
                                 state_q == SEQ_DUMMY || state_q == SEQ_DATA);

  // Capture every request field on acceptance so the requester may change
  // its inputs as soon as the handshake completes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_q       <= '0;
      addr_q      <= '0;
      addr_en_q   <= 1'b0;
      dummy_q     <= '0;
      len_q       <= '0;
      wr_q        <= 1'b0;
      cmd_mode_q  <= '0;
      addr_mode_q <= '0;
      data_mode_q <= '0;
    end else if (accept) begin
      cmd_q       <= cmd_i;
      addr_q      <= addr_i;
      addr_en_q   <= addr_en_i;
      dummy_q     <= dummy_i;
      len_q       <= len_i;
      wr_q        <= wr_i;
      cmd_mode_q  <= cmd_mode_i;
      addr_mode_q <= addr_mode_i;
      data_mode_q <= data_mode_i;
    end
  end

  // State register plus counters and the registered output pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= SEQ_IDLE;
      pend_q        <= 1'b0;
      byte_idx_q    <= '0;
      cnt_q         <= '0;
      wait_q        <= '0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      byte_idx_q    <= byte_idx_d;
      cnt_q         <= cnt_d;
      wait_q        <= wait_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  // Next-state and shifter command logic. pend_q marks an outstanding byte
  // so a new sh_start_o is issued only after the shifter reports done.
  // An abort suppresses any start in its own cycle and overrides whatever
  // the phase logic decided, including a coincident read byte.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    byte_idx_d    = byte_idx_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    sh_start_o    = 1'b0;
    sh_byte_o     = 8'h00;
    sh_mode_o     = LANE_SINGLE;
    sh_dir_o      = 1'b0;
    wdata_ready_o = 1'b0;
    enter_tail    = 1'b0;
    go_desel      = 1'b0;

    unique case (state_q)
      SEQ_IDLE: begin
        if (req_valid_i) begin
          state_d = SEQ_CMD;
          pend_d  = 1'b0;
        end
      end

      SEQ_CMD: begin
        sh_byte_o = cmd_q;
        sh_mode_o = lane_norm(cmd_mode_q);
        sh_dir_o  = 1'b1;
        if (!pend_q && !abort_i) begin
          sh_start_o = 1'b1;
          pend_d     = 1'b1;
        end
        if (byte_done) begin
          pend_d = 1'b0;
          if (addr_en_q) begin
            state_d    = SEQ_ADDR;
            byte_idx_d = 2'(ADDR_BYTES - 1);
          end else begin
            enter_tail = 1'b1;
          end
        end
      end

      SEQ_ADDR: begin
        sh_byte_o = addr_q[{byte_idx_q, 3'b000} +: 8];
        sh_mode_o = lane_norm(addr_mode_q);
        sh_dir_o  = 1'b1;
        if (!pend_q && !abort_i) begin
          sh_start_o = 1'b1;
          pend_d     = 1'b1;
        end
        if (byte_done) begin
          pend_d = 1'b0;
          if (byte_idx_q == 2'd0) begin
            enter_tail = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q - 2'd1;
          end
        end
      end

      SEQ_DUMMY: begin
        if (wait_q <= 4'd1) begin
          wait_d = '0;
          if (len_q != 9'd0) begin
            state_d = SEQ_DATA;
            cnt_d   = len_q;
          end else begin
            go_desel = 1'b1;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      SEQ_DATA: begin
        sh_mode_o = lane_norm(data_mode_q);
        sh_dir_o  = wr_q;
        if (wr_q) begin
          sh_byte_o = wdata_i;
          if (!pend_q && wdata_valid_i && !abort_i) begin
            sh_start_o    = 1'b1;
            wdata_ready_o = 1'b1;
            pend_d        = 1'b1;
          end
        end else if (!pend_q && !abort_i) begin
          sh_start_o = 1'b1;
          pend_d     = 1'b1;
        end
        if (byte_done) begin
          pend_d = 1'b0;
          cnt_d  = cnt_q - 9'd1;
          if (!wr_q) begin
            rdata_valid_d = 1'b1;
            rdata_d       = sh_byte_i;
          end
          if (cnt_q == 9'd1) begin
            go_desel = 1'b1;
          end
        end
      end

      SEQ_DESEL: begin
        pend_d = 1'b0;
        if (wait_q <= 4'd1) begin
          wait_d  = '0;
          state_d = SEQ_IDLE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    // After the header bytes: dummy gap, then data, then deselect, each
    // skipped when its length is zero.
    if (enter_tail) begin
      if (dummy_q != 4'd0) begin
        state_d = SEQ_DUMMY;
        wait_d  = dummy_q;
      end else if (len_q != 9'd0) begin
        state_d = SEQ_DATA;
        cnt_d   = len_q;
      end else begin
        go_desel = 1'b1;
      end
    end

    if (go_desel) begin
      state_d = SEQ_DESEL;
      wait_d  = 4'(CS_HIGH_CYCLES);
      done_d  = 1'b1;
      pend_d  = 1'b0;
    end

    if (abort_now) begin
      state_d       = SEQ_DESEL;
      wait_d        = 4'(CS_HIGH_CYCLES);
      done_d        = 1'b1;
      aborted_d     = 1'b1;
      pend_d        = 1'b0;
      rdata_valid_d = 1'b0;
      rdata_d       = rdata_q;
    end
  end

  // Chip select is low only while a transaction phase is active, so an
  // asynchronous reset forces it high immediately through state_q.
  assign cs_o          = (state_q == SEQ_IDLE) || (state_q == SEQ_DESEL);
  assign req_ready_o   = (state_q == SEQ_IDLE);
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;

endmodule

// File: tb/tb_qspi_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_qspi_cmd_sequencer
// Directed bench for qspi_cmd_sequencer with a behavioural byte shifter,
// a toggling write-data source and scoreboards for shifter bytes, read
// bytes and completion pulses.
// ---------------------------------------------------------------------------
module tb_qspi_cmd_sequencer;

  localparam int CS_HIGH = 2;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [7:0]  cmd_i = '0;
  logic [31:0] addr_i = '0;
  logic        addr_en_i = 1'b0;
  logic [3:0]  dummy_i = '0;
  logic [8:0]  len_i = '0;
  logic        wr_i = 1'b0;
  logic [1:0]  cmd_mode_i = '0;
  logic [1:0]  addr_mode_i = '0;
  logic [1:0]  data_mode_i = '0;
  logic        abort_i = 1'b0;
  logic [7:0]  wdata_i = '0;
  logic        wdata_valid_i = 1'b0;
  logic        wdata_ready_o;
  logic [7:0]  rdata_o;
  logic        rdata_valid_o;
  logic        done_o;
  logic        aborted_o;
  logic        cs_o;
  logic        sh_start_o;
  logic [7:0]  sh_byte_o;
  logic [1:0]  sh_mode_o;
  logic        sh_dir_o;
  logic        sh_done_i = 1'b0;
  logic [7:0]  sh_byte_i = '0;

  qspi_cmd_sequencer #(.ADDR_BYTES(3), .CS_HIGH_CYCLES(CS_HIGH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .cmd_i(cmd_i), .addr_i(addr_i), .addr_en_i(addr_en_i),
    .dummy_i(dummy_i), .len_i(len_i), .wr_i(wr_i),
    .cmd_mode_i(cmd_mode_i), .addr_mode_i(addr_mode_i), .data_mode_i(data_mode_i),
    .abort_i(abort_i),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .done_o(done_o), .aborted_o(aborted_o), .cs_o(cs_o),
    .sh_start_o(sh_start_o), .sh_byte_o(sh_byte_o), .sh_mode_o(sh_mode_o),
    .sh_dir_o(sh_dir_o), .sh_done_i(sh_done_i), .sh_byte_i(sh_byte_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] b;
    logic [1:0] m;
    logic       d;
    int         gap;
    bit         wrData;
  } shExp_t;

  shExp_t     expShQ[$];
  logic [7:0] expRdQ[$];
  logic       expDoneQ[$];

  int assertCount = 0;
  int failCount   = 0;

  int cycleNum      = 0;
  int lastDoneCycle = -100;
  int startCount    = 0;
  int readyCount    = 0;
  int doneCount     = 0;
  int deselLen      = 0;
  bit deselArmed    = 1'b0;

  // Shifter model controls.
  logic [7:0] rdSeed      = 8'h40;
  int         abortAtRead = 0;
  int         readDoneNum = 0;
  bit         shBusy      = 1'b0;
  int         shTimer     = 0;
  logic       shDir       = 1'b0;

  // Write source controls.
  bit wrSrcActive = 1'b0;
  int wrIdx       = 0;
  int wrTotal     = 0;

  function automatic logic [7:0] wrPattern(input int k);
    logic [7:0] v;
    v = 8'(k);
    return v ^ 8'h5A;
  endfunction

  function automatic logic [1:0] expMode(input logic [1:0] raw);
    return (raw == 2'b11) ? 2'b00 : raw;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: everything sampled on the falling edge.
  always @(negedge clk_i) begin
    shExp_t e;
    cycleNum++;
    if (sh_start_o) begin
      startCount++;
      if (expShQ.size() == 0) begin
        checkOutput("unexpected sh_start", 32'd1, 32'd0);
      end else begin
        e = expShQ.pop_front();
        checkOutput("sh_byte", {24'd0, sh_byte_o}, {24'd0, e.b});
        checkOutput("sh_mode", {30'd0, sh_mode_o}, {30'd0, e.m});
        checkOutput("sh_dir", {31'd0, sh_dir_o}, {31'd0, e.d});
        if (e.gap >= 0) checkOutput("start gap", cycleNum - lastDoneCycle - 1, e.gap);
        if (e.wrData) begin
          checkOutput("wdata_ready at start", {31'd0, wdata_ready_o}, 32'd1);
          checkOutput("wdata_valid at start", {31'd0, wdata_valid_i}, 32'd1);
        end
      end
    end
    if (wdata_ready_o) begin
      readyCount++;
      if (!sh_start_o) checkOutput("wdata_ready without start", 32'd0, 32'd1);
    end
    if (sh_done_i) lastDoneCycle = cycleNum;
    if (rdata_valid_o) begin
      if (expRdQ.size() == 0) checkOutput("unexpected rdata_valid", 32'd1, 32'd0);
      else checkOutput("rdata", {24'd0, rdata_o}, {24'd0, expRdQ.pop_front()});
    end
    if (done_o) begin
      doneCount++;
      if (expDoneQ.size() == 0) checkOutput("unexpected done", 32'd1, 32'd0);
      else checkOutput("aborted_o", {31'd0, aborted_o}, {31'd0, expDoneQ.pop_front()});
      checkOutput("cs_o at done", {31'd0, cs_o}, 32'd1);
      deselArmed = 1'b1;
      deselLen   = 0;
    end
    if (deselArmed) begin
      if (req_ready_o) begin
        checkOutput("desel length", deselLen, CS_HIGH);
        deselArmed = 1'b0;
      end else if (cs_o) begin
        deselLen++;
      end
    end
  end

  // Byte shifter model: random latency, returns rdSeed-based read bytes and
  // can raise abort_i on the same cycle as a chosen read completion.
  always begin
    logic seenStart;
    logic seenDir;
    @(negedge clk_i);
    seenStart = sh_start_o;
    seenDir   = sh_dir_o;
    @(posedge clk_i);
    #1;
    sh_done_i = 1'b0;
    abort_i   = 1'b0;
    if (shBusy) begin
      if (shTimer == 0) begin
        sh_done_i = 1'b1;
        shBusy    = 1'b0;
        if (!shDir) begin
          sh_byte_i = rdSeed;
          rdSeed    = rdSeed + 8'd1;
          readDoneNum++;
          if (abortAtRead != 0 && readDoneNum == abortAtRead) begin
            abort_i     = 1'b1;
            abortAtRead = 0;
          end
        end else begin
          sh_byte_i = 8'hEE;
        end
      end else begin
        shTimer--;
      end
    end
    if (seenStart) begin
      shBusy  = 1'b1;
      shDir   = seenDir;
      shTimer = int'($urandom_range(0, 2));
    end
  end

  // Write data source with a randomly toggling valid.
  always begin
    logic seenReady;
    @(negedge clk_i);
    seenReady = wdata_ready_o;
    @(posedge clk_i);
    #1;
    if (wrSrcActive) begin
      if (seenReady) wrIdx++;
      if (wrIdx >= wrTotal) begin
        wdata_valid_i = 1'b0;
        wrSrcActive   = 1'b0;
      end else begin
        wdata_valid_i = 1'($urandom_range(0, 1));
        wdata_i       = wrPattern(wrIdx);
      end
    end
  end

  // Pushes expectations, issues the request and optionally waits for done.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] addr,
                               input bit addrEn, input int dummy, input int len,
                               input bit wr, input logic [1:0] cm, input logic [1:0] am,
                               input logic [1:0] dm, input int abortAt, input bit expectDone);
    shExp_t e;
    int nStarts;
    int nRd;
    int doneBefore;
    logic [7:0] seed;
    @(negedge clk_i);
    nStarts = (abortAt != 0) ? abortAt : len;
    nRd     = wr ? 0 : ((abortAt != 0) ? abortAt - 1 : len);
    seed    = 8'h40 + 8'(cycleNum);
    rdSeed      = seed;
    readDoneNum = 0;
    abortAtRead = abortAt;
    wrIdx       = 0;
    wrTotal     = len;
    wrSrcActive = wr && (len != 0);
    e = '{b: cmd, m: expMode(cm), d: 1'b1, gap: -1, wrData: 1'b0};
    expShQ.push_back(e);
    if (addrEn) begin
      for (int i = 2; i >= 0; i--) begin
        e = '{b: addr[8*i +: 8], m: expMode(am), d: 1'b1, gap: 0, wrData: 1'b0};
        expShQ.push_back(e);
      end
    end
    for (int k = 0; k < nStarts; k++) begin
      if (wr) e = '{b: wrPattern(k), m: expMode(dm), d: 1'b1, gap: -1, wrData: 1'b1};
      else    e = '{b: 8'h00, m: expMode(dm), d: 1'b0, gap: (k == 0) ? dummy : 0, wrData: 1'b0};
      expShQ.push_back(e);
    end
    for (int k = 0; k < nRd; k++) expRdQ.push_back(seed + 8'(k));
    if (expectDone) expDoneQ.push_back(abortAt != 0);
    doneBefore = doneCount;

    @(posedge clk_i);
    #1;
    req_valid_i = 1'b1;
    cmd_i       = cmd;
    addr_i      = addr;
    addr_en_i   = addrEn;
    dummy_i     = 4'(dummy);
    len_i       = 9'(len);
    wr_i        = wr;
    cmd_mode_i  = cm;
    addr_mode_i = am;
    data_mode_i = dm;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    cmd_i       = 8'hFF;
    addr_i      = 32'hFFFF_FFFF;
    @(negedge clk_i);
    checkOutput("cs_o low after accept", {31'd0, cs_o}, 32'd0);
    checkOutput("req_ready_o low when busy", {31'd0, req_ready_o}, 32'd0);
    if (expectDone) begin
      for (int i = 0; i < 6000 && doneCount == doneBefore; i++) @(negedge clk_i);
      checkOutput("done within budget", {31'd0, doneCount > doneBefore}, 32'd1);
      repeat (4) @(negedge clk_i);
    end
  endtask

  initial begin
    int readyBefore;
    int startBefore;
    int doneBefore;

    #1;
    checkOutput("reset cs_o", {31'd0, cs_o}, 32'd1);
    checkOutput("reset req_ready_o", {31'd0, req_ready_o}, 32'd1);
    checkOutput("reset sh_start_o", {31'd0, sh_start_o}, 32'd0);
    checkOutput("reset sh_byte_o", {24'd0, sh_byte_o}, 32'd0);
    checkOutput("reset sh_mode_o", {30'd0, sh_mode_o}, 32'd0);
    checkOutput("reset sh_dir_o", {31'd0, sh_dir_o}, 32'd0);
    checkOutput("reset rdata_o", {24'd0, rdata_o}, 32'd0);
    checkOutput("reset pulses", {28'd0, done_o, aborted_o, rdata_valid_o, wdata_ready_o}, 32'd0);
    repeat (3) @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("[TB] single read 0x03 @0x123456 len 4");
    applyStimulus(8'h03, 32'h0012_3456, 1'b1, 0, 4, 1'b0, 2'b00, 2'b00, 2'b00, 0, 1'b1);

    $display("[TB] quad read 0xEB with 6 dummy cycles");
    applyStimulus(8'hEB, 32'h00A1_B2C3, 1'b1, 6, 2, 1'b0, 2'b00, 2'b10, 2'b10, 0, 1'b1);

    $display("[TB] write enable 0x06, reserved cmd mode");
    applyStimulus(8'h06, 32'h0, 1'b0, 0, 0, 1'b1, 2'b11, 2'b00, 2'b00, 0, 1'b1);

    $display("[TB] page program 256 bytes, toggling wdata_valid");
    readyBefore = readyCount;
    applyStimulus(8'h32, 32'h00AB_CDEF, 1'b1, 0, 256, 1'b1, 2'b00, 2'b00, 2'b10, 0, 1'b1);
    checkOutput("wdata_ready pulses", readyCount - readyBefore, 256);

    $display("[TB] abort on second read completion");
    applyStimulus(8'h0B, 32'h0055_6677, 1'b1, 0, 4, 1'b0, 2'b00, 2'b00, 2'b00, 2, 1'b1);

    $display("[TB] reset during address phase");
    startBefore = startCount;
    doneBefore  = doneCount;
    applyStimulus(8'h0B, 32'h0065_4321, 1'b1, 0, 4, 1'b0, 2'b00, 2'b00, 2'b00, 0, 1'b0);
    for (int i = 0; i < 200 && startCount < startBefore + 2; i++) @(negedge clk_i);
    checkOutput("reached address phase", {31'd0, startCount >= startBefore + 2}, 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("async reset cs_o", {31'd0, cs_o}, 32'd1);
    checkOutput("async reset sh_start_o", {31'd0, sh_start_o}, 32'd0);
    checkOutput("async reset done_o", {31'd0, done_o}, 32'd0);
    expShQ.delete();
    expRdQ.delete();
    repeat (2) @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    @(negedge clk_i);
    checkOutput("req_ready_o after reset", {31'd0, req_ready_o}, 32'd1);
    repeat (10) @(negedge clk_i);
    checkOutput("no done after reset", doneCount, doneBefore);

    $display("[TB] dual read status 0x05 after reset");
    applyStimulus(8'h05, 32'h0, 1'b0, 0, 1, 1'b0, 2'b01, 2'b00, 2'b01, 0, 1'b1);

    checkOutput("shifter scoreboard drained", expShQ.size(), 0);
    checkOutput("rdata scoreboard drained", expRdQ.size(), 0);
    checkOutput("done scoreboard drained", expDoneQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/qspi_cmd_sequencer.md
QSPI_CMD_SEQUENCER -- requirements
Module: qspi_cmd_sequencer

Interface
REQ-001 Parameter ADDR_BYTES, default 3, number of address bytes sent when addr_en_i=1; legal values 3 or 4.
REQ-002 Parameter CS_HIGH_CYCLES, default 2, minimum cs_o deassert time in clk_i cycles between transactions; legal range 1..15.
REQ-003 clk_i  in  1  clock; all logic on posedge clk_i.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 req_valid_i / req_ready_o  in/out  1/1  transaction request handshake.
REQ-006 cmd_i  in  8  command opcode.
REQ-007 addr_i  in  32  address; low ADDR_BYTES bytes used.
REQ-008 addr_en_i  in  1  address phase present.
REQ-009 dummy_i  in  4  dummy clk_i cycles, 0..15.
REQ-010 len_i  in  9  data bytes, 0..256.
REQ-011 wr_i  in  1  1 = data written to flash, 0 = read.
REQ-012 cmd_mode_i, addr_mode_i, data_mode_i  in  2 each  lane mode: 00 single, 01 dual, 10 quad, 11 treated as single.
REQ-013 abort_i  in  1  terminate current transaction.
REQ-014 wdata_i / wdata_valid_i / wdata_ready_o  in/in/out  8/1/1  write byte stream.
REQ-015 rdata_o / rdata_valid_o  out/out  8/1  read byte stream, no backpressure.
REQ-016 done_o / aborted_o  out/out  1/1  one-cycle completion pulse; aborted_o qualifies done_o.
REQ-017 cs_o  out  1  flash chip select, active-low.
REQ-018 sh_start_o, sh_byte_o[7:0], sh_mode_o[1:0], sh_dir_o  out  shifter byte command (sh_dir_o 1 = drive flash).
REQ-019 sh_done_i, sh_byte_i[7:0]  in  shifter byte completion pulse and captured byte.

Function
REQ-020 States IDLE, CMD, ADDR, DUMMY, DATA, DESEL; req_ready_o=1 only in IDLE.
REQ-021 Request accepted on req_valid_i&&req_ready_o; all request fields registered; next cycle state=CMD, cs_o=0.
REQ-022 Each byte phase: sh_start_o pulses one cycle with sh_byte_o/sh_mode_o/sh_dir_o valid; next sh_start_o only after sh_done_i.
REQ-023 CMD sends cmd_i (cmd_mode_i, sh_dir_o=1); then ADDR if addr_en_i, else DUMMY if dummy_i!=0, else DATA if len_i!=0, else DESEL.
REQ-024 ADDR sends ADDR_BYTES bytes MSB first in addr_mode_i, sh_dir_o=1.
REQ-025 DUMMY holds cs_o=0 for exactly dummy_i cycles, no sh_start_o.
REQ-026 DATA write: sh_start_o asserted only when wdata_valid_i; wdata_ready_o pulses the same cycle, sh_byte_o=wdata_i.
REQ-027 DATA read: sh_dir_o=0, sh_byte_o=0; each sh_done_i gives rdata_valid_o pulse next cycle with rdata_o=sh_byte_i.
REQ-028 Byte counter 9-bit, decrements per sh_done_i; DATA exits to DESEL when counter hits 0.
REQ-029 DESEL: cs_o=1 for CS_HIGH_CYCLES cycles; done_o pulses on first DESEL cycle; then IDLE.
REQ-030 abort_i in CMD/ADDR/DUMMY/DATA: next cycle DESEL, done_o and aborted_o pulse; no further sh_start_o.
REQ-031 abort_i coincident with sh_done_i: abort wins; that read byte not delivered.
REQ-032 abort_i in IDLE or DESEL ignored; sh_done_i outside byte phases ignored.

Reset
REQ-033 Reset: state IDLE, cs_o=1, req_ready_o=1, all pulses/strobes 0, sh_byte_o=0, sh_mode_o=0, sh_dir_o=0, rdata_o=0, counters 0.
REQ-034 Reset mid-transaction: outputs take reset values immediately, no done_o.

Structure
REQ-035 Package qspi_pkg holds lane-mode enum, sequencer state enum, CS_HIGH_CYCLES default; shared with the shifter.
REQ-036 Single flat module; no sub-module required.

Verification
REQ-037 Read 0x03, addr 0x123456, single, len 4 -> bytes 03,12,34,56 out; 4 rdata_valid_o pulses; done_o; cs_o high 2 cycles.
REQ-038 Quad read 0xEB, addr quad, dummy 6, len 2 -> exactly 6 idle cs_o=0 cycles between last address done and first data start.
REQ-039 Write 0x06, no addr, len 0 -> one byte, done_o, aborted_o=0.
REQ-040 Page program len 256 with wdata_valid_i toggling -> 256 wdata_ready_o pulses, no sh_start_o while valid low.
REQ-041 abort_i on same cycle as 2nd data sh_done_i -> 1 rdata_valid_o only, done_o&aborted_o, cs_o=1 next cycle.
REQ-042 rst_n_i low during ADDR -> cs_o=1 asynchronously, req_ready_o=1 after release.
